// File: rtl/tcam_pkg.sv
// Shared TCAM defaults, index-width helper and match-array FSM encodings.
// The priority encoder downstream uses the same package.
package tcam_pkg;
  localparam int KEY_WIDTH   = 32;
  localparam int CHUNK_WIDTH = 4;
  localparam int NUM_CHUNKS  = KEY_WIDTH / CHUNK_WIDTH;
  localparam int DEPTH       = 2 ** CHUNK_WIDTH;
  localparam int MAX_RULE    = 64;

  // Ceiling log2, usable in constant expressions.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/disram_chunk.sv
// One key chunk of rule storage: DEPTH x MAX_RULE LUTRAM.
// Asynchronous read port; write port has a per-column (per-rule) enable.
module disram_chunk #(
  parameter int CHUNK_WIDTH = 4,
  parameter int MAX_RULE    = 64
) (
  input  logic                   clk,
  input  logic [CHUNK_WIDTH-1:0] rd_addr,
  output logic [MAX_RULE-1:0]    rd_data,
  input  logic [CHUNK_WIDTH-1:0] wr_addr,
  input  logic [MAX_RULE-1:0]    wr_en,
  input  logic [MAX_RULE-1:0]    wr_data
);
  localparam int DEPTH = 2 ** CHUNK_WIDTH;

  logic [MAX_RULE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int r = 0; r < MAX_RULE; r++) begin
      if (wr_en[r]) mem[wr_addr][r] <= wr_data[r];
    end
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/disram_tcam_match.sv
// TCAM match array: per-chunk LUTRAM lookup ANDed into a registered match vector,
// plus the INIT clear and rule insert/delete engine that rewrites one column.
module disram_tcam_match #(
  parameter int MAX_RULE    = tcam_pkg::MAX_RULE,
  parameter int KEY_WIDTH   = tcam_pkg::KEY_WIDTH,
  parameter int CHUNK_WIDTH = tcam_pkg::CHUNK_WIDTH,
  parameter int ADDR_WIDTH  = tcam_pkg::log2(MAX_RULE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [KEY_WIDTH-1:0]  key,
  output logic                  key_ready,
  output logic [MAX_RULE-1:0]   match_vec,
  output logic                  match_vec_valid,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic                  upd_en,
  input  logic [ADDR_WIDTH-1:0] upd_addr,
  input  logic [KEY_WIDTH-1:0]  upd_value,
  input  logic [KEY_WIDTH-1:0]  upd_mask,
  output logic                  upd_done
);
  localparam int NUM_CHUNKS = KEY_WIDTH / CHUNK_WIDTH;
  localparam int DEPTH      = 2 ** CHUNK_WIDTH;

  import tcam_pkg::*;

  logic [1:0]             state;
  logic [CHUNK_WIDTH-1:0] cnt;
  logic                   en_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [KEY_WIDTH-1:0]   value_q;
  logic [KEY_WIDTH-1:0]   mask_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic                   key_q_valid;
  logic [MAX_RULE-1:0]    wr_en;
  logic [MAX_RULE-1:0]    wr_data [NUM_CHUNKS];
  logic [MAX_RULE-1:0]    rd_data [NUM_CHUNKS];
  logic [MAX_RULE-1:0]    match_all;
  logic                   key_accept;
  logic                   upd_accept;

  assign key_ready  = (state == ST_IDLE);
  assign upd_ready  = (state == ST_IDLE);
  assign key_accept = key_valid && key_ready;
  assign upd_accept = upd_valid && upd_ready;

  // INIT clears every column at address cnt; WRITE touches only the target rule.
  always_comb begin
    wr_en = '0;
    if (state == ST_INIT) wr_en = '1;
    else if (state == ST_WRITE) wr_en = MAX_RULE'(1) << addr_q;
  end

  for (genvar c = 0; c < NUM_CHUNKS; c++) begin : g_chunk
    logic col_bit;
    assign col_bit = en_q &&
      (((cnt ^ value_q[c*CHUNK_WIDTH +: CHUNK_WIDTH]) & mask_q[c*CHUNK_WIDTH +: CHUNK_WIDTH]) == '0);
    assign wr_data[c] = (state == ST_WRITE) ? {MAX_RULE{col_bit}} : '0;

    disram_chunk #(
      .CHUNK_WIDTH(CHUNK_WIDTH),
      .MAX_RULE   (MAX_RULE)
    ) u_chunk (
      .clk    (clk),
      .rd_addr(key_q[c*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .rd_data(rd_data[c]),
      .wr_addr(cnt),
      .wr_en  (wr_en),
      .wr_data(wr_data[c])
    );
  end

  always_comb begin
    match_all = '1;
    for (int c = 0; c < NUM_CHUNKS; c++) match_all &= rd_data[c];
  end

  // The key is registered first and read on the next edge, so a lookup accepted
  // together with an update reads memory before the first WRITE edge lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_INIT;
      cnt             <= '0;
      en_q            <= 1'b0;
      addr_q          <= '0;
      value_q         <= '0;
      mask_q          <= '0;
      key_q           <= '0;
      key_q_valid     <= 1'b0;
      match_vec       <= '0;
      match_vec_valid <= 1'b0;
      upd_done        <= 1'b0;
    end else begin
      key_q_valid     <= key_accept;
      match_vec_valid <= key_q_valid;
      if (key_accept) key_q <= key;
      if (key_q_valid) match_vec <= match_all;

      case (state)
        ST_INIT, ST_WRITE: begin
          if (cnt == CHUNK_WIDTH'(DEPTH - 1)) begin
            cnt   <= '0;
            state <= (state == ST_INIT) ? ST_IDLE : ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (upd_accept) begin
            en_q    <= upd_en;
            addr_q  <= upd_addr;
            value_q <= upd_value;
            mask_q  <= upd_mask;
            cnt     <= '0;
            state   <= ST_WRITE;
          end
        end
        default: begin
          // DONE: raise upd_done for one cycle, then return to IDLE.
          if (!upd_done) begin
            upd_done <= 1'b1;
          end else begin
            upd_done <= 1'b0;
            state    <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_disram_tcam_match.sv
// Directed bench for disram_tcam_match: init timing, inserts, deletes, overwrite,
// simultaneous lookup/update and reset during WRITE.
module tb_disram_tcam_match;
  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [31:0] key;
  logic        key_ready;
  logic [63:0] match_vec;
  logic        match_vec_valid;
  logic        upd_valid;
  logic        upd_ready;
  logic        upd_en;
  logic [5:0]  upd_addr;
  logic [31:0] upd_value;
  logic [31:0] upd_mask;
  logic        upd_done;

  int tests = 0;
  int fails = 0;

  disram_tcam_match dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_valid      (key_valid),
    .key            (key),
    .key_ready      (key_ready),
    .match_vec      (match_vec),
    .match_vec_valid(match_vec_valid),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_en         (upd_en),
    .upd_addr       (upd_addr),
    .upd_value      (upd_value),
    .upd_mask       (upd_mask),
    .upd_done       (upd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!key_ready && n < 60) begin
      step();
      n++;
    end
    check("ready_timeout", 64'(key_ready), 64'd1);
  endtask

  task automatic lookup(input string tag, input logic [31:0] k, input logic [63:0] exp);
    wait_ready();
    key_valid = 1'b1;
    key       = k;
    step();
    key_valid = 1'b0;
    step();
    check({tag, "_valid"}, 64'(match_vec_valid), 64'd1);
    check(tag, match_vec, exp);
  endtask

  task automatic update(input logic en, input logic [5:0] addr,
                        input logic [31:0] val, input logic [31:0] msk);
    int n;
    wait_ready();
    upd_valid = 1'b1;
    upd_en    = en;
    upd_addr  = addr;
    upd_value = val;
    upd_mask  = msk;
    step();
    upd_valid = 1'b0;
    n = 0;
    while (!upd_done && n < 60) begin
      step();
      n++;
    end
    check("upd_done_latency", 64'(n), 64'd17);
    step();
    check("upd_done_pulse", 64'(upd_done), 64'd0);
    check("upd_ready_after", 64'(upd_ready), 64'd1);
  endtask

  initial begin
    int n;
    int done_seen;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key       = '0;
    upd_valid = 1'b0;
    upd_en    = 1'b0;
    upd_addr  = '0;
    upd_value = '0;
    upd_mask  = '0;
    repeat (3) step();

    check("rst_match_vec", match_vec, 64'd0);
    check("rst_match_valid", 64'(match_vec_valid), 64'd0);
    check("rst_key_ready", 64'(key_ready), 64'd0);
    check("rst_upd_ready", 64'(upd_ready), 64'd0);
    check("rst_upd_done", 64'(upd_done), 64'd0);

    rst_n = 1'b1;
    n = 0;
    while (!key_ready && n < 60) begin
      step();
      n++;
    end
    check("init_cycles", 64'(n), 64'd16);

    lookup("empty_zero", 32'h0000_0000, 64'd0);
    lookup("empty_ones", 32'hFFFF_FFFF, 64'd0);

    update(1'b1, 6'd5, 32'hC0A8_0001, 32'hFFFF_FFFF);
    lookup("r5_hit", 32'hC0A8_0001, 64'h1 << 5);
    lookup("r5_miss", 32'hC0A8_0002, 64'd0);

    update(1'b1, 6'd0, 32'h0A0B_0000, 32'hFFFF_0000);
    update(1'b1, 6'd63, 32'h0000_0000, 32'h0000_0000);
    lookup("r0_r63", 32'h0A0B_1234, (64'h1 << 63) | 64'h1);
    lookup("r63_only", 32'h0A0C_1234, 64'h1 << 63);

    update(1'b0, 6'd63, 32'h0000_0000, 32'h0000_0000);
    lookup("del_r63", 32'h1234_5678, 64'd0);
    update(1'b1, 6'd0, 32'h0A0C_0000, 32'hFFFF_0000);
    lookup("ovr_old", 32'h0A0B_1234, 64'd0);
    lookup("ovr_new", 32'h0A0C_1234, 64'h1);

    // Lookup and update accepted on the same edge.
    wait_ready();
    key_valid = 1'b1;
    key       = 32'hC0A8_0001;
    upd_valid = 1'b1;
    upd_en    = 1'b1;
    upd_addr  = 6'd6;
    upd_value = 32'hC0A8_0001;
    upd_mask  = 32'hFFFF_FFFF;
    step();
    key_valid = 1'b0;
    upd_valid = 1'b0;
    step();
    check("simul_valid", 64'(match_vec_valid), 64'd1);
    check("simul_pre_update", match_vec, 64'h1 << 5);
    key_valid = 1'b1;
    check("write_key_ready", 64'(key_ready), 64'd0);
    step();
    step();
    check("write_key_dropped", 64'(match_vec_valid), 64'd0);
    key_valid = 1'b0;
    n = 0;
    while (!upd_done && n < 60) begin
      step();
      n++;
    end
    check("simul_upd_done", 64'(upd_done), 64'd1);
    lookup("simul_post", 32'hC0A8_0001, (64'h1 << 5) | (64'h1 << 6));

    // Reset pulse in the middle of WRITE.
    wait_ready();
    upd_valid = 1'b1;
    upd_en    = 1'b1;
    upd_addr  = 6'd7;
    upd_value = 32'h0;
    upd_mask  = 32'h0;
    step();
    upd_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    check("midrst_ready", 64'(upd_ready), 64'd0);
    check("midrst_valid", 64'(match_vec_valid), 64'd0);
    rst_n = 1'b1;
    n = 0;
    done_seen = 0;
    while (!key_ready && n < 60) begin
      step();
      n++;
      if (upd_done) done_seen++;
    end
    check("midrst_init_cycles", 64'(n), 64'd16);
    check("midrst_no_done", 64'(done_seen), 64'd0);
    lookup("midrst_r5_r6_gone", 32'hC0A8_0001, 64'd0);
    lookup("midrst_r0_gone", 32'h0A0C_1234, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
